// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, ALU op codes,
// instruction field positions and the default halt word.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_IMM0 = 3'b110;
  localparam logic [2:0] OP_IMM1 = 3'b111;

  localparam int unsigned FLD_A_MSB  = 15;
  localparam int unsigned FLD_A_LSB  = 12;
  localparam int unsigned FLD_B_MSB  = 11;
  localparam int unsigned FLD_B_LSB  = 8;
  localparam int unsigned FLD_OP_MSB = 7;
  localparam int unsigned FLD_OP_LSB = 5;
  localparam int unsigned FLD_W_MSB  = 4;
  localparam int unsigned FLD_W_LSB  = 1;
  localparam int unsigned FLD_WE     = 0;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  // Multiply/divide write result registers on every presented clock, so they
  // are masked to a pass op until writeback. Immediates go through untouched.
  function automatic logic [2:0] alu_presented(input logic [2:0] op, input logic in_wb);
    if (!in_wb && (op == OP_MUL || op == OP_DIV))
      return OP_PASS;
    return op;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue controller: fetches ROM words, splits them into
// register-file fields and sequences read, ALU execute and writeback.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 8,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                CLK_In,
  input  logic                RST_In,
  input  logic                Run_In,
  output logic [PC_WIDTH-1:0] Rom_Addr,
  input  logic [15:0]         Rom_Data,
  output logic [3:0]          Aaddr,
  output logic [3:0]          Baddr,
  output logic [2:0]          Instruction_alu,
  output logic [3:0]          Write_addr,
  output logic                Write_Enable,
  output logic                Alu_Start,
  input  logic                Alu_Done,
  output logic [PC_WIDTH-1:0] Pc_Out,
  output logic                Busy,
  output logic                Halted
);

  state_t              r_state;
  logic [15:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;

  state_t              w_next;
  logic [15:0]         w_ir_next;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic                w_fields_on;
  logic                w_busy_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (Run_In) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = (Rom_Data == HALT_WORD) ? ST_HALT : ST_READ;
      ST_READ:   w_next = ST_EXEC;
      ST_EXEC:   if (Alu_Done) w_next = ST_WB;
      ST_WB:     w_next = Run_In ? ST_FETCH : ST_IDLE;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the IR value feeding them
  // must already include the word being latched on the DECODE->READ edge.
  always_comb begin
    w_ir_next   = (r_state == ST_DECODE && w_next == ST_READ) ? Rom_Data : r_ir;
    w_pc_next   = (r_state == ST_WB) ? r_pc + PC_WIDTH'(1) : r_pc;
    w_fields_on = (w_next == ST_READ) || (w_next == ST_EXEC) || (w_next == ST_WB);
    w_busy_next = w_fields_on || (w_next == ST_FETCH) || (w_next == ST_DECODE);
  end

  always_ff @(posedge CLK_In) begin
    if (RST_In) begin
      r_state         <= ST_IDLE;
      r_ir            <= '0;
      r_pc            <= '0;
      Rom_Addr        <= '0;
      Aaddr           <= '0;
      Baddr           <= '0;
      Instruction_alu <= '0;
      Write_addr      <= '0;
      Write_Enable    <= 1'b0;
      Alu_Start       <= 1'b0;
      Busy            <= 1'b0;
      Halted          <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ir    <= w_ir_next;
      r_pc    <= w_pc_next;
      if (w_next == ST_FETCH)
        Rom_Addr <= w_pc_next;
      Aaddr           <= w_fields_on ? w_ir_next[FLD_A_MSB:FLD_A_LSB] : '0;
      Baddr           <= w_fields_on ? w_ir_next[FLD_B_MSB:FLD_B_LSB] : '0;
      Write_addr      <= w_fields_on ? w_ir_next[FLD_W_MSB:FLD_W_LSB] : '0;
      Instruction_alu <= w_fields_on
                         ? alu_presented(w_ir_next[FLD_OP_MSB:FLD_OP_LSB], w_next == ST_WB)
                         : '0;
      Write_Enable    <= (w_next == ST_WB) && w_ir_next[FLD_WE];
      Alu_Start       <= (r_state == ST_READ);
      Busy            <= w_busy_next;
      Halted          <= (w_next == ST_HALT);
    end
  end

  assign Pc_Out = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes hand-computed per-cycle
// output vectors, monitors pop and compare on the falling clock edge.
module tb_instr_sequencer;

  bit clk;
  always #5 clk = ~clk;

  // main DUT (PC_WIDTH = 8)
  logic        rst, run, done;
  logic [7:0]  rom_addr, pc_out;
  logic [15:0] rom_data;
  logic [3:0]  aaddr, baddr, waddr;
  logic [2:0]  alu;
  logic        we, start, busy, halted;
  logic [15:0] rom [0:255];

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  instr_sequencer #(.PC_WIDTH(8)) dut (
    .CLK_In(clk), .RST_In(rst), .Run_In(run),
    .Rom_Addr(rom_addr), .Rom_Data(rom_data),
    .Aaddr(aaddr), .Baddr(baddr), .Instruction_alu(alu),
    .Write_addr(waddr), .Write_Enable(we), .Alu_Start(start),
    .Alu_Done(done), .Pc_Out(pc_out), .Busy(busy), .Halted(halted)
  );

  // second DUT with a 2-bit PC to exercise wrap
  logic        rst2, run2;
  logic [1:0]  rom_addr2, pc_out2;
  logic [15:0] rom_data2;
  logic [3:0]  aaddr2, baddr2, waddr2;
  logic [2:0]  alu2;
  logic        we2, start2, busy2, halted2;

  assign rom_data2 = 16'h1221;

  instr_sequencer #(.PC_WIDTH(2)) dut2 (
    .CLK_In(clk), .RST_In(rst2), .Run_In(run2),
    .Rom_Addr(rom_addr2), .Rom_Data(rom_data2),
    .Aaddr(aaddr2), .Baddr(baddr2), .Instruction_alu(alu2),
    .Write_addr(waddr2), .Write_Enable(we2), .Alu_Start(start2),
    .Alu_Done(1'b1), .Pc_Out(pc_out2), .Busy(busy2), .Halted(halted2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_q [$];
  string       nm_q  [$];
  logic [3:0]  exp2_q [$];

  function automatic logic [34:0] ev(input logic b, input logic h, input logic st,
                                     input logic w, input logic [2:0] op,
                                     input logic [3:0] a, input logic [3:0] bb,
                                     input logic [3:0] wa, input logic [7:0] pc,
                                     input logic [7:0] ra);
    return {b, h, st, w, op, a, bb, wa, pc, ra};
  endfunction

  // Monitor: field order busy,halted,start,we,alu,A,B,waddr,pc,rom_addr
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [34:0] e, act;
      string nm;
      e   = exp_q.pop_front();
      nm  = nm_q.pop_front();
      act = {busy, halted, start, we, alu, aaddr, baddr, waddr, pc_out, rom_addr};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (busy,halted,start,we,alu,A,B,wa,pc,rom)",
                 nm, act, e);
      end
    end
  end

  always @(negedge clk) begin
    if (start2 === 1'b1) begin
      logic [3:0] e2;
      n_checks++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_extra_start: got rom=%0d pc=%0d expected no Alu_Start",
                 rom_addr2, pc_out2);
      end else begin
        e2 = exp2_q.pop_front();
        if ({rom_addr2, pc_out2} !== e2) begin
          n_fail++;
          $display("FAIL wrap_fetch: got rom=%0d pc=%0d expected rom=%0d pc=%0d",
                   rom_addr2, pc_out2, e2[3:2], e2[1:0]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic ru, input logic d,
                      input logic [34:0] e, input string nm);
    rst  = r;
    run  = ru;
    done = d;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  localparam logic [34:0] ZERO = 35'd0;

  initial begin
    rst = 1; run = 0; done = 0; rst2 = 1; run2 = 0;
    rom_clear();
    rom[0] = 16'h1221;
    rom[1] = 16'hFFFF;

    // basic instruction then halt
    step(1, 0, 0, ZERO, "reset");
    rst2 = 0;
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t1_fetch");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t1_decode");
    step(0, 1, 1, ev(1,0,0,0,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t1_read");
    step(0, 1, 1, ev(1,0,1,0,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t1_exec");
    step(0, 1, 1, ev(1,0,0,1,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t1_wb");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "t1_fetch1");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "t1_decode1");
    step(0, 1, 1, ev(0,1,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "halt_enter");
    for (int i = 0; i < 4; i++)
      step(0, logic'(i % 2), 1, ev(0,1,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "halt_hold");
    step(1, 1, 0, ZERO, "halt_reset");

    // immediate op, run dropped at writeback
    rom_clear();
    rom[0] = 16'h34C7;
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t2_fetch");
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t2_decode");
    step(0, 1, 0, ev(1,0,0,0,3'd6,4'd3,4'd4,4'd3,8'd0,8'd0), "t2_read_imm");
    step(0, 1, 1, ev(1,0,1,0,3'd6,4'd3,4'd4,4'd3,8'd0,8'd0), "t2_exec_imm");
    step(0, 1, 1, ev(1,0,0,1,3'd6,4'd3,4'd4,4'd3,8'd0,8'd0), "t2_wb_imm");
    step(0, 0, 1, ev(0,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd0), "t2_idle");
    step(1, 0, 0, ZERO, "t2_reset");

    // multiply with slow ALU, then run drop during EXEC, resume, halt
    rom_clear();
    rom[0] = 16'h5640;
    rom[1] = 16'h7A13;
    rom[2] = 16'hFFFF;
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t3_fetch");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t3_decode");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd5,4'd6,4'd0,8'd0,8'd0), "t3_read_mul");
    step(0, 1, 1, ev(1,0,1,0,3'd0,4'd5,4'd6,4'd0,8'd0,8'd0), "t3_exec1_mul");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, ev(1,0,0,0,3'd0,4'd5,4'd6,4'd0,8'd0,8'd0), "t3_exec_wait");
    step(0, 1, 1, ev(1,0,0,0,3'd2,4'd5,4'd6,4'd0,8'd0,8'd0), "t3_wb_mul");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "t4_fetch");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd1,8'd1), "t4_decode");
    step(0, 1, 1, ev(1,0,0,0,3'd0,4'd7,4'd10,4'd9,8'd1,8'd1), "t4_read");
    step(0, 1, 0, ev(1,0,1,0,3'd0,4'd7,4'd10,4'd9,8'd1,8'd1), "t4_exec");
    step(0, 0, 1, ev(1,0,0,1,3'd0,4'd7,4'd10,4'd9,8'd1,8'd1), "t4_wb_after_drop");
    step(0, 0, 1, ev(0,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd2,8'd1), "t4_idle");
    step(0, 0, 1, ev(0,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd2,8'd1), "t4_idle_hold");
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd2,8'd2), "t4_resume_fetch");
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd2,8'd2), "t4_resume_decode");
    step(0, 1, 0, ev(0,1,0,0,3'd0,4'd0,4'd0,4'd0,8'd2,8'd2), "t4_halt");
    step(1, 0, 0, ZERO, "t4_reset");

    // reset while in EXEC
    rom_clear();
    rom[0] = 16'h1221;
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t5_fetch");
    step(0, 1, 0, ev(1,0,0,0,3'd0,4'd0,4'd0,4'd0,8'd0,8'd0), "t5_decode");
    step(0, 1, 0, ev(1,0,0,0,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t5_read");
    step(0, 1, 0, ev(1,0,1,0,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t5_exec1");
    step(0, 1, 0, ev(1,0,0,0,3'd1,4'd1,4'd2,4'd0,8'd0,8'd0), "t5_exec2");
    step(1, 1, 1, ZERO, "t5_reset_in_exec");
    step(0, 0, 1, ZERO, "t5_post_reset");

    // PC wrap on the 2-bit instance: five fetches 0,1,2,3,0
    rst2 = 1;
    @(negedge clk); #1;
    rst2 = 0;
    exp2_q.push_back({2'd0, 2'd0});
    exp2_q.push_back({2'd1, 2'd1});
    exp2_q.push_back({2'd2, 2'd2});
    exp2_q.push_back({2'd3, 2'd3});
    exp2_q.push_back({2'd0, 2'd0});
    run2 = 1;
    repeat (25) @(negedge clk);
    #1;
    run2 = 0;
    repeat (8) @(negedge clk);
    #1;

    for (int i = 0; i < 10 && (exp_q.size() > 0 || exp2_q.size() > 0); i++)
      @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending entries expected 0/0",
               exp_q.size(), exp2_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/issue controller that drives the register-file (RAM) port set.
- Fetches 16-bit instruction words from a synchronous program ROM and splits them into register-file fields: A address [15:12], B address/immediate [11:8], ALU op [7:5], write address [4:1], write enable [0].
- Sequences operand read, ALU execution (Alu_Start/Alu_Done handshake) and writeback, so the register file sees each field only in the correct cycle.

Parameters:
- PC_WIDTH, 8, program counter / ROM address width; PC wraps from 2^PC_WIDTH-1 to 0.
- HALT_WORD, 16'hFFFF, instruction word that stops the sequencer.

Ports:
- CLK_In  in  1  single clock; all state updates on rising edge.
- RST_In  in  1  synchronous, active-high reset.
- Run_In  in  1  level; 1 = execute, 0 = stop after the current instruction.
- Rom_Addr  out  PC_WIDTH  program ROM address (ROM returns data 1 cycle later).
- Rom_Data  in  16  program ROM read data.
- Aaddr  out  4  register-file operand A address.
- Baddr  out  4  register-file operand B address or 4-bit immediate.
- Instruction_alu  out  3  ALU op presented to the register file and the ALU.
- Write_addr  out  4  register-file write address.
- Write_Enable  out  1  register-file write strobe.
- Alu_Start  out  1  one-cycle pulse: operands valid, ALU begins.
- Alu_Done  in  1  ALU result valid on Write_data (may arrive in the same cycle as Alu_Start).
- Pc_Out  out  PC_WIDTH  address of the instruction currently in flight.
- Busy  out  1  high in FETCH through WB.
- Halted  out  1  high in HALT.

Behaviour:
- Reset: state IDLE, PC=0, IR=0, all outputs 0. Reset wins over every other event. Reset in any state aborts with no write: Write_Enable is 0 from the next edge.
- States and transitions:
  - IDLE: go to FETCH when Run_In=1.
  - FETCH: Rom_Addr=PC. Always goes to DECODE.
  - DECODE: if Rom_Data==HALT_WORD, go to HALT with PC unchanged. Otherwise IR<=Rom_Data and go to READ.
  - READ: present IR fields. The register file registers its operands at the end of this cycle. Go to EXEC.
  - EXEC: Alu_Start=1 in the first EXEC cycle only. Stay in EXEC until Alu_Done=1, then go to WB.
  - WB: Write_Enable=IR[0] and PC<=PC+1 (wrapping). If Run_In=1 go to FETCH, else go to IDLE.
  - HALT: Halted=1. Exit only via reset.
- Field outputs: Aaddr, Baddr and Write_addr hold IR fields from READ through WB. They are 0 in IDLE, FETCH, DECODE and HALT.
- Instruction_alu:
  - Equals IR[7:5] in READ, EXEC and WB.
  - Exception: multiply (3'b010) and divide (3'b011) write result registers 14/15 on every clock they are presented, so in READ and EXEC these codes are driven as 3'b000. The true code is driven only in the WB cycle.
  - Immediate ops (3'b110, 3'b111) are passed through unaltered in READ, so operand B is loaded with the immediate.
- Write_Enable is high only in WB. It is never asserted for a HALT word.
- Write_addr=0 is issued normally; the register file forces register 0 to zero.
- Alu_Done outside EXEC is ignored. Alu_Done in the same cycle as Alu_Start means EXEC lasts 1 cycle.
- Minimum instruction time is 5 cycles (FETCH, DECODE, READ, EXEC, WB). Back-to-back instructions have no idle gap while Run_In=1.
- Run_In falling mid-instruction: the instruction completes through WB, then the sequencer enters IDLE. Run_In rising again resumes at the current PC.
- PC wrap: an instruction at address 2^PC_WIDTH-1 is followed by a fetch from 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, DECODE, READ, EXEC, WB, HALT);
  - ALU op constants OP_MUL=3'b010, OP_DIV=3'b011, OP_IMM0=3'b110, OP_IMM1=3'b111, OP_PASS=3'b000;
  - instruction field bit ranges;
  - HALT_WORD default.
- No sub-module: field slicing is trivial. Single module, one FSM plus PC/IR registers.

Test Plan:
- Reset then Run_In=1; ROM[0]=16'h1221 (A=1, B=2, op=001, wr=0, we=1), Alu_Done tied 1 -> Rom_Addr=0 in FETCH; Aaddr=1, Baddr=2 in READ; one Alu_Start pulse; Write_Enable=1 only in cycle 5; PC=1 afterward.
- ROM[0]=16'h34C7 (op=110 immediate, B=4, wr=3, we=1) -> Instruction_alu=3'b110 from READ through WB; Baddr=4; Write_addr=3; single write in WB.
- ROM[0]=16'h5640 (op=010 multiply), Alu_Done delayed 4 cycles -> Instruction_alu=000 in READ/EXEC and 010 only in WB; Alu_Start high exactly one cycle; EXEC lasts 4 cycles.
- ROM[1]=16'hFFFF -> after the instruction at PC 0 completes, HALT entered; Halted=1; Write_Enable stays 0; Pc_Out=1 held; Run_In toggling has no effect until RST_In.
- Run_In dropped during EXEC -> WB still completes (write occurs); state goes to IDLE; Busy=0; re-assert Run_In -> fetch from PC=1.
- RST_In asserted in EXEC -> next edge all outputs 0, no Write_Enable pulse, PC=0; PC_WIDTH=2 run of 5 instructions -> Rom_Addr sequence 0,1,2,3,0.
